round_key_scheduler: RTL and testbench
======================================

Name: round_key_scheduler

Overview:
- Control-and-storage stage directly upstream of key_expansion.
- Accepts a masked 128-bit cipher key, drives key_expansion ten times (round 1..10), and captures each produced round key into an 11-entry round-key store (slot 0 = cipher key).
- Serves stored round keys to the cipher datapath through a registered read port.
- Owns the first_round / drdy_i sequencing that key_expansion expects.

Parameters:
- d, 4, number of mask bits per byte; byte width W = 8+d, state width S = 16*W.
- NR, 10, number of expanded round keys; store depth NR+1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begin expansion of key_in
- key_in  in  S  masked cipher key; sampled on accepted start; byte layout identical to key_expansion in/out
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when all NR round keys are stored
- keys_valid  out  1  high after done until next accepted start or reset
- ke_drdy_i  out  1  one-cycle request pulse to key_expansion
- ke_first_round  out  1  rc reset request to key_expansion
- ke_in  out  S  previous round key fed to key_expansion
- ke_out  in  S  round key produced by key_expansion
- ke_drdy_o  in  1  key_expansion output-ready pulse
- rk_req  in  1  read request
- rk_idx  in  4  slot index 0..NR
- rk_valid  out  1  read response strobe
- rk_hit  out  1  response slot is populated and rk_idx <= NR
- rk_data  out  S  round-key data

Behaviour:
- Reset:
  - State IDLE; round counter 0; all store slots zero; populated flags clear.
  - busy, done, keys_valid, ke_drdy_i, ke_first_round, rk_valid and rk_hit are 0; ke_in and rk_data are 0.
- States:
  - IDLE --start--> LOAD.
  - LOAD: slot0 <= key_in, populated[0] <= 1, rnd <= 1, keys_valid <= 0, busy <= 1. Next state ISSUE.
  - ISSUE: ke_drdy_i = 1 for exactly one cycle; ke_first_round = 1 in the same cycle iff rnd == 1. Next state WAIT.
  - WAIT: hold until ke_drdy_o. On ke_drdy_o: slot[rnd] <= ke_out, populated[rnd] <= 1, go to STORE.
  - STORE: if rnd == NR, go to DONE; else rnd <= rnd+1, go to ISSUE.
  - DONE: done = 1 for one cycle, keys_valid <= 1, busy <= 0. Next state IDLE.
- ke_in:
  - Combinationally equals slot[rnd-1] outside IDLE, 0 in IDLE.
  - Stable from ISSUE through the ke_drdy_o cycle.
- Latency: start to done = 2 + NR*(2 + L_ke) cycles, where L_ke = cycles from ke_drdy_i to ke_drdy_o (variable because of S-box). No cycle is counted by a fixed timer.
- start while busy: ignored, no effect.
- start in the same cycle as done: ignored; a start on the following cycle is accepted.
- ke_drdy_o outside WAIT: ignored; the store is unchanged.
- Read port:
  - rk_req sampled every cycle regardless of state; response exactly 1 cycle later: rk_valid = 1 and registered rk_data/rk_hit.
  - idx <= NR and slot populated: rk_hit = 1, rk_data = slot.
  - Otherwise: rk_hit = 0, rk_data = 0.
  - Back-to-back requests give one response per cycle.
  - A read of slot k in the same cycle it is written returns the old content with rk_hit = old flag.
- New start: LOAD clears populated[1..NR], so stale keys from the previous expansion are never reported as hits. Slot data stays unchanged until overwritten.
- Reset mid-operation: immediate return to the reset state; key_expansion is reset by the same rst.
- rnd is 4 bits and never exceeds NR; no wrap.

Test Plan:
- d=0, identity L, P=0x1B; start with key 2b7e151628aed2a6abf7158809cf4f3c -> rk_idx=1 returns a0fafe1788542cb123a339392a6c7605; rk_idx=10 returns d014f9a8c9ee2589e13f0cc8b6630ca6; done pulses once; ke_first_round high only in the round-1 ISSUE cycle.
- Read during expansion: rk_idx=5 polled each cycle -> rk_hit=0 until the cycle after slot 5 is stored, then hit with FIPS round-5 key d4d1c6f87c839d87caf2b8bc11f915bc.
- rk_idx=11 and 15 -> rk_valid=1, rk_hit=0, rk_data=0; rk_idx=0 after done -> cipher key.
- start pulsed while busy in round 4 -> ignored; round-10 key still d014f9a8c9ee2589e13f0cc8b6630ca6; done exactly once.
- rst asserted in WAIT of round 6 -> all outputs 0 next cycle; new start with key 000102030405060708090a0b0c0d0e0f -> round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Second start after done with a different key -> keys_valid drops in LOAD; rk_idx=3 gives rk_hit=0 until the new round-3 key is stored.

Source files
------------

// File: rtl/round_key_scheduler_if.sv
// Bus bundle for round_key_scheduler: host control, key_expansion handshake
// and the round-key read port. The scheduler uses the slave view.
interface round_key_scheduler_if #(
    parameter int d = 4
);
    localparam int W = 8 + d;
    localparam int S = 16 * W;

    // host control
    logic         start;
    logic [S-1:0] key_in;
    logic         busy;
    logic         done;
    logic         keys_valid;

    // key_expansion handshake
    logic         ke_drdy_i;
    logic         ke_first_round;
    logic [S-1:0] ke_in;
    logic [S-1:0] ke_out;
    logic         ke_drdy_o;

    // round-key read port
    logic         rk_req;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_hit;
    logic [S-1:0] rk_data;

    modport master (
        output start, key_in, ke_out, ke_drdy_o, rk_req, rk_idx,
        input  busy, done, keys_valid, ke_drdy_i, ke_first_round, ke_in,
               rk_valid, rk_hit, rk_data
    );

    modport slave (
        input  start, key_in, ke_out, ke_drdy_o, rk_req, rk_idx,
        output busy, done, keys_valid, ke_drdy_i, ke_first_round, ke_in,
               rk_valid, rk_hit, rk_data
    );
endinterface

// File: rtl/round_key_scheduler.sv
// Round-key scheduler: sequences key_expansion through NR rounds, stores
// every round key (slot 0 = cipher key) and serves them over a registered
// read port. Round completion is driven purely by ke_drdy_o, never a timer.
module round_key_scheduler #(
    parameter int d  = 4,
    parameter int NR = 10
) (
    input  logic               clk,
    input  logic               rst,
    round_key_scheduler_if.slave bus
);
    localparam int W = 8 + d;
    localparam int S = 16 * W;
    localparam logic [3:0] NR_L = 4'(NR);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, STORE, DONE} state_t;

    state_t       state, state_nx;
    logic [3:0]   rnd;
    logic [S-1:0] slot [0:NR];
    logic [NR:0]  populated;
    logic         keys_valid_q;
    logic         rk_valid_q;
    logic         rk_hit_q;
    logic [S-1:0] rk_data_q;

    logic         start_acc;
    logic         capture;
    logic [3:0]   prev_idx;
    logic [3:0]   rd_idx;
    logic         rd_ok;

    // A start is only honoured from IDLE; busy/DONE cycles swallow it.
    assign start_acc = (state == IDLE) && bus.start;
    // ke_drdy_o only counts while waiting for it.
    assign capture   = (state == WAIT) && bus.ke_drdy_o;
    assign prev_idx  = (rnd == 4'd0) ? 4'd0 : rnd - 4'd1;
    // Out-of-range indices are folded to slot 0 for the array access only;
    // rd_ok still reports a miss for them.
    assign rd_idx    = (bus.rk_idx <= NR_L) ? bus.rk_idx : 4'd0;
    assign rd_ok     = (bus.rk_idx <= NR_L) && populated[rd_idx];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = LOAD;
            LOAD:    state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (bus.ke_drdy_o) state_nx = STORE;
            STORE:   state_nx = (rnd == NR_L) ? DONE : ISSUE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Round counter: primed to 1 as LOAD is entered, advanced in STORE, saturates at NR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                rnd <= 4'd0;
        else if (start_acc)                     rnd <= 4'd1;
        else if (state == STORE && rnd != NR_L) rnd <= rnd + 4'd1;
    end

    // Round-key store. The LOAD-state work (cipher key capture, dropping the
    // stale populated flags) lands on the accepting edge so key_in is sampled
    // with the start pulse and LOAD already sees slot 0. Slot data of old
    // rounds is kept; only the flags hide it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NR; i++) slot[i] <= '0;
            populated <= '0;
        end else begin
            if (start_acc) begin
                slot[0]   <= bus.key_in;
                populated <= {{NR{1'b0}}, 1'b1};
            end
            if (capture) begin
                slot[rnd]      <= bus.ke_out;
                populated[rnd] <= 1'b1;
            end
        end
    end

    // keys_valid: cleared by an accepted start, set when DONE retires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                keys_valid_q <= 1'b0;
        else if (start_acc)     keys_valid_q <= 1'b0;
        else if (state == DONE) keys_valid_q <= 1'b1;
    end

    // Read port: one registered response per request, independent of the FSM.
    // A same-cycle write is not forwarded, so the old slot/flag is returned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rk_valid_q <= 1'b0;
            rk_hit_q   <= 1'b0;
            rk_data_q  <= '0;
        end else begin
            rk_valid_q <= bus.rk_req;
            rk_hit_q   <= bus.rk_req && rd_ok;
            rk_data_q  <= (bus.rk_req && rd_ok) ? slot[rd_idx] : '0;
        end
    end

    // FSM outputs; ke_in follows slot[rnd-1] so it holds from ISSUE until capture.
    always_comb begin
        bus.busy           = 1'b0;
        bus.done           = 1'b0;
        bus.ke_drdy_i      = 1'b0;
        bus.ke_first_round = 1'b0;
        bus.ke_in          = '0;
        if (state != IDLE) begin
            bus.busy  = 1'b1;
            bus.ke_in = slot[prev_idx];
        end
        if (state == ISSUE) begin
            bus.ke_drdy_i      = 1'b1;
            bus.ke_first_round = (rnd == 4'd1);
        end
        if (state == DONE) bus.done = 1'b1;
    end

    assign bus.keys_valid = keys_valid_q;
    assign bus.rk_valid   = rk_valid_q;
    assign bus.rk_hit     = rk_hit_q;
    assign bus.rk_data    = rk_data_q;

endmodule

// File: tb/tb_round_key_scheduler.sv
// Directed bench for round_key_scheduler with d=0 (plain AES-128 bytes).
// A behavioural key_expansion answers each ke_drdy_i with the next AES round
// key after 1..3 cycles; expected round keys are the FIPS-197 constants.
module tb_round_key_scheduler;
    localparam logic [127:0] K_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A_R3  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    localparam logic [127:0] A_R5  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    localparam logic [127:0] A_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K_B   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] B_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    // L per round = 1,2,3,1,2,3,1,2,3,1 -> 2 + 10*2 + 19
    localparam int EXP_LAT = 41;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    round_key_scheduler_if #(.d(0)) bus();
    round_key_scheduler #(.d(0), .NR(10)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_chk  = 0;
    int n_fail = 0;

    // ---------------- AES helpers for the key_expansion model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int i = 1; i < 256; i++) if (gmul(x, 8'(i)) == 8'h01) inv = 8'(i);
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] kexp(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        n0 = w0 ^ t; n1 = w1 ^ n0; n2 = w2 ^ n1; n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // ---------------- behavioural key_expansion ----------------
    logic [127:0] m_out, m_res, m_res_nx;
    logic [7:0]   m_rc, m_rc_nx;
    logic         m_drdy, m_pend;
    int           m_idx, m_idx_nx, m_cnt;
    logic         spur_drdy;
    logic [127:0] spur_data;

    assign m_rc_nx  = bus.ke_first_round ? 8'h01 : gmul(m_rc, 8'h02);
    assign m_idx_nx = bus.ke_first_round ? 1 : m_idx + 1;
    assign m_res_nx = kexp(bus.ke_in, m_rc_nx);
    assign bus.ke_drdy_o = m_drdy | spur_drdy;
    assign bus.ke_out    = spur_drdy ? spur_data : m_out;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_drdy <= 1'b0; m_pend <= 1'b0; m_out <= '0; m_res <= '0;
            m_rc <= 8'h00; m_idx <= 0; m_cnt <= 0;
        end else begin
            m_drdy <= 1'b0;
            if (bus.ke_drdy_i) begin
                m_rc  <= m_rc_nx;
                m_idx <= m_idx_nx;
                m_res <= m_res_nx;
                if (((m_idx_nx - 1) % 3) == 0) begin
                    m_drdy <= 1'b1;
                    m_out  <= m_res_nx;
                end else begin
                    m_pend <= 1'b1;
                    m_cnt  <= (m_idx_nx - 1) % 3;
                end
            end else if (m_pend) begin
                if (m_cnt == 1) begin
                    m_drdy <= 1'b1;
                    m_out  <= m_res;
                    m_pend <= 1'b0;
                end
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic do_read(input logic [3:0] idx, output logic v, output logic h, output logic [127:0] dat);
        @(negedge clk);
        bus.rk_req = 1'b1; bus.rk_idx = idx;
        @(negedge clk);
        v = bus.rk_valid; h = bus.rk_hit; dat = bus.rk_data;
        bus.rk_req = 1'b0;
    endtask

    task automatic run_to_done(input logic [127:0] key, output int lat, output int ndone);
        lat = -1; ndone = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.key_in = key;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) begin ndone++; if (lat < 0) lat = i; end
            if (lat >= 0 && i >= lat + 3) break;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic v, h; logic [127:0] dat;
        @(negedge clk); @(negedge clk);
        n_chk++;
        if ({bus.busy, bus.done, bus.keys_valid, bus.ke_drdy_i, bus.ke_first_round, bus.rk_valid, bus.rk_hit} !== 7'b0
            || bus.ke_in !== '0 || bus.rk_data !== '0) begin
            n_fail++; $display("FAIL reset_outputs: ctl %b ke_in %h rk_data %h, expected all zero",
                {bus.busy, bus.done, bus.keys_valid, bus.ke_drdy_i, bus.ke_first_round, bus.rk_valid, bus.rk_hit},
                bus.ke_in, bus.rk_data);
        end
        rst = 1'b0;
        do_read(4'd0, v, h, dat);
        n_chk++;
        if ({v, h} !== 2'b10 || dat !== '0) begin
            n_fail++; $display("FAIL reset_store_empty: valid/hit %b%b data %h, expected 10 0", v, h, dat);
        end
    endtask

    task automatic test_expand_fips;
        int since, lat, ndone, nissue, nfr, frbad;
        logic exp_h; logic [127:0] exp_d;
        logic v, h; logic [127:0] dat;
        since = -1; lat = -1; ndone = 0; nissue = 0; nfr = 0; frbad = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.key_in = K_A; bus.rk_req = 1'b1; bus.rk_idx = 4'd5;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (since >= 0) since++;
            exp_h = (since >= 2);
            exp_d = exp_h ? A_R5 : '0;
            n_chk++;
            if ({bus.rk_valid, bus.rk_hit} !== {1'b1, exp_h} || bus.rk_data !== exp_d) begin
                n_fail++; $display("FAIL poll_idx5 cycle %0d: valid/hit %b%b data %h, expected 1%b %h",
                    i, bus.rk_valid, bus.rk_hit, bus.rk_data, exp_h, exp_d);
            end
            if (bus.ke_drdy_i) nissue++;
            if (bus.ke_first_round) begin
                nfr++;
                if (!(bus.ke_drdy_i && nissue == 1)) frbad++;
            end
            if (bus.ke_drdy_o && m_idx == 5 && since < 0) since = 0;
            if (bus.done) begin ndone++; if (lat < 0) lat = i; end
            if (lat >= 0 && i >= lat + 3) break;
        end
        bus.rk_req = 1'b0;
        n_chk++;
        if (lat !== EXP_LAT) begin n_fail++; $display("FAIL latency: got %0d cycles, expected %0d", lat, EXP_LAT); end
        n_chk++;
        if (ndone !== 1) begin n_fail++; $display("FAIL done_once: got %0d pulses, expected 1", ndone); end
        n_chk++;
        if (nissue !== 10) begin n_fail++; $display("FAIL issue_count: got %0d, expected 10", nissue); end
        n_chk++;
        if (nfr !== 1 || frbad !== 0) begin
            n_fail++; $display("FAIL first_round: %0d pulses (%0d misplaced), expected 1 in round-1 ISSUE", nfr, frbad);
        end
        n_chk++;
        if ({bus.keys_valid, bus.busy} !== 2'b10) begin
            n_fail++; $display("FAIL keys_valid_after_done: valid/busy %b%b, expected 10", bus.keys_valid, bus.busy);
        end
        do_read(4'd1, v, h, dat);
        n_chk++;
        if ({v, h} !== 2'b11 || dat !== A_R1) begin
            n_fail++; $display("FAIL read_rk1: valid/hit %b%b data %h, expected 11 %h", v, h, dat, A_R1);
        end
        do_read(4'd10, v, h, dat);
        n_chk++;
        if ({v, h} !== 2'b11 || dat !== A_R10) begin
            n_fail++; $display("FAIL read_rk10: valid/hit %b%b data %h, expected 11 %h", v, h, dat, A_R10);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]   idxs [6];
        logic         hits [6];
        logic [127:0] dats [6];
        idxs = '{4'd0, 4'd1, 4'd10, 4'd11, 4'd15, 4'd5};
        hits = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        dats = '{K_A, A_R1, A_R10, 128'h0, 128'h0, A_R5};
        @(negedge clk);
        bus.rk_req = 1'b1; bus.rk_idx = idxs[0];
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_chk++;
            if ({bus.rk_valid, bus.rk_hit} !== {1'b1, hits[k-1]} || bus.rk_data !== dats[k-1]) begin
                n_fail++; $display("FAIL b2b_idx%0d: valid/hit %b%b data %h, expected 1%b %h",
                    idxs[k-1], bus.rk_valid, bus.rk_hit, bus.rk_data, hits[k-1], dats[k-1]);
            end
            if (k < 6) bus.rk_idx = idxs[k];
            else       bus.rk_req = 1'b0;
        end
        @(negedge clk);
        n_chk++;
        if ({bus.rk_valid, bus.rk_hit} !== 2'b00 || bus.rk_data !== '0) begin
            n_fail++; $display("FAIL no_req_no_resp: valid/hit %b%b data %h, expected 00 0",
                bus.rk_valid, bus.rk_hit, bus.rk_data);
        end
    endtask

    task automatic test_spurious_drdy;
        logic v, h; logic [127:0] dat;
        @(negedge clk);
        spur_drdy = 1'b1; spur_data = '1;
        @(negedge clk);
        spur_drdy = 1'b0;
        n_chk++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL spurious_state: busy %b, expected 0", bus.busy); end
        do_read(4'd10, v, h, dat);
        n_chk++;
        if ({v, h} !== 2'b11 || dat !== A_R10) begin
            n_fail++; $display("FAIL spurious_rk10: valid/hit %b%b data %h, expected 11 %h", v, h, dat, A_R10);
        end
    endtask

    task automatic test_busy_start;
        int lat, lat2, ndone;
        logic hit4;
        logic v, h; logic [127:0] dat;
        lat = -1; lat2 = -1; ndone = 0; hit4 = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.key_in = K_A;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (!hit4 && bus.ke_drdy_i && m_idx_nx == 4) begin
                hit4 = 1'b1; bus.start = 1'b1; bus.key_in = K_B;
            end
            if (bus.done) begin
                ndone++;
                if (lat < 0) begin
                    lat = i; bus.start = 1'b1; bus.key_in = K_B;   // start in the done cycle
                end else if (lat2 < 0) lat2 = i;
            end
            if (lat >= 0 && i == lat + 1) begin
                n_chk++;
                if (bus.busy !== 1'b0 || bus.keys_valid !== 1'b1) begin
                    n_fail++; $display("FAIL start_at_done_ignored: busy/keys_valid %b%b, expected 01",
                        bus.busy, bus.keys_valid);
                end
                bus.start = 1'b1; bus.key_in = K_A;             // following cycle: accepted
            end
            if (lat >= 0 && i == lat + 2) begin
                n_chk++;
                if (bus.busy !== 1'b1) begin
                    n_fail++; $display("FAIL start_after_done_accepted: busy %b, expected 1", bus.busy);
                end
            end
            if (lat2 >= 0 && i >= lat2 + 2) break;
        end
        n_chk++;
        if (lat !== EXP_LAT || lat2 !== lat + 1 + EXP_LAT || ndone !== 2) begin
            n_fail++; $display("FAIL busy_start_timing: done at %0d and %0d (%0d pulses), expected %0d and %0d (2)",
                lat, lat2, ndone, EXP_LAT, 2 * EXP_LAT + 1);
        end
        do_read(4'd10, v, h, dat);
        n_chk++;
        if ({v, h} !== 2'b11 || dat !== A_R10) begin
            n_fail++; $display("FAIL busy_start_rk10: valid/hit %b%b data %h, expected 11 %h", v, h, dat, A_R10);
        end
        do_read(4'd0, v, h, dat);
        n_chk++;
        if ({v, h} !== 2'b11 || dat !== K_A) begin
            n_fail++; $display("FAIL busy_start_rk0: valid/hit %b%b data %h, expected 11 %h", v, h, dat, K_A);
        end
    endtask

    task automatic test_rst_mid;
        logic found;
        int lat, ndone;
        logic v, h; logic [127:0] dat;
        found = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.key_in = K_A; bus.rk_req = 1'b1; bus.rk_idx = 4'd0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.ke_drdy_i && m_idx_nx == 6) begin found = 1'b1; break; end
        end
        n_chk++;
        if (!found) begin n_fail++; $display("FAIL rst_mid_reach_round6: got no round-6 issue, expected one"); end
        @(negedge clk);
        n_chk++;
        if (bus.busy !== 1'b1 || bus.ke_in === '0) begin
            n_fail++; $display("FAIL rst_mid_in_wait: busy %b ke_in %h, expected busy 1 and nonzero ke_in", bus.busy, bus.ke_in);
        end
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({bus.busy, bus.done, bus.keys_valid, bus.ke_drdy_i, bus.ke_first_round, bus.rk_valid, bus.rk_hit} !== 7'b0
            || bus.ke_in !== '0 || bus.rk_data !== '0) begin
            n_fail++; $display("FAIL rst_mid_outputs: ctl %b ke_in %h rk_data %h, expected all zero",
                {bus.busy, bus.done, bus.keys_valid, bus.ke_drdy_i, bus.ke_first_round, bus.rk_valid, bus.rk_hit},
                bus.ke_in, bus.rk_data);
        end
        bus.rk_req = 1'b0;
        rst = 1'b0;
        do_read(4'd1, v, h, dat);
        n_chk++;
        if ({v, h} !== 2'b10 || dat !== '0) begin
            n_fail++; $display("FAIL rst_mid_store_cleared: valid/hit %b%b data %h, expected 10 0", v, h, dat);
        end
        run_to_done(K_B, lat, ndone);
        n_chk++;
        if (lat !== EXP_LAT || ndone !== 1) begin
            n_fail++; $display("FAIL rst_mid_rerun: done at %0d (%0d pulses), expected %0d (1)", lat, ndone, EXP_LAT);
        end
        do_read(4'd10, v, h, dat);
        n_chk++;
        if ({v, h} !== 2'b11 || dat !== B_R10) begin
            n_fail++; $display("FAIL rst_mid_rk10: valid/hit %b%b data %h, expected 11 %h", v, h, dat, B_R10);
        end
        do_read(4'd0, v, h, dat);
        n_chk++;
        if ({v, h} !== 2'b11 || dat !== K_B) begin
            n_fail++; $display("FAIL rst_mid_rk0: valid/hit %b%b data %h, expected 11 %h", v, h, dat, K_B);
        end
    endtask

    task automatic test_restart;
        int since, lat;
        logic exp_h; logic [127:0] exp_d;
        since = -1; lat = -1;
        n_chk++;
        if (bus.keys_valid !== 1'b1) begin
            n_fail++; $display("FAIL restart_pre_valid: keys_valid %b, expected 1", bus.keys_valid);
        end
        @(negedge clk);
        bus.start = 1'b1; bus.key_in = K_A; bus.rk_req = 1'b1; bus.rk_idx = 4'd3;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (i == 1) begin
                n_chk++;
                if ({bus.keys_valid, bus.busy} !== 2'b01) begin
                    n_fail++; $display("FAIL restart_load: keys_valid/busy %b%b, expected 01", bus.keys_valid, bus.busy);
                end
            end
            if (since >= 0) since++;
            if (i >= 3) begin
                exp_h = (since >= 2);
                exp_d = exp_h ? A_R3 : '0;
                n_chk++;
                if ({bus.rk_valid, bus.rk_hit} !== {1'b1, exp_h} || bus.rk_data !== exp_d) begin
                    n_fail++; $display("FAIL restart_poll_idx3 cycle %0d: valid/hit %b%b data %h, expected 1%b %h",
                        i, bus.rk_valid, bus.rk_hit, bus.rk_data, exp_h, exp_d);
                end
            end
            if (bus.ke_drdy_o && m_idx == 3 && since < 0) since = 0;
            if (bus.done && lat < 0) lat = i;
            if (lat >= 0 && i >= lat + 2) break;
        end
        bus.rk_req = 1'b0;
        n_chk++;
        if (lat !== EXP_LAT) begin n_fail++; $display("FAIL restart_latency: got %0d, expected %0d", lat, EXP_LAT); end
    endtask

    initial begin
        bus.start = 1'b0; bus.key_in = '0; bus.rk_req = 1'b0; bus.rk_idx = 4'd0;
        spur_drdy = 1'b0; spur_data = '0;
        test_reset();
        test_expand_fips();
        test_back_to_back();
        test_spurious_drdy();
        test_busy_start();
        test_rst_mid();
        test_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
